microwave_sm: RTL and testbench

Control state machine for a microwave oven. It takes the Add30 button, the door sensor and a timer-zero flag. It drives load, increment and decrement strobes to an external 7-bit cook timer, and the magnetron-on and beeper outputs. The cook timer and its arithmetic live outside this block; this block only issues commands to it.

---
 rtl/microwave_pkg.sv | 22 ++
 rtl/microwave_sm.sv | 121 ++++++++++++
 tb/tb_microwave_sm.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave oven control state machine.
//
// Contents:
//   state_t   - controller state encoding (OFF, ON, BEEP)
//   COOK_INC  - seconds added or loaded by one Add30 press
//   BEEP_TIME - length of the beep phase in timer ticks
//
// The cook timer itself lives outside the controller. These constants
// describe the values that the controller's strobes load or add, so the
// timer and the benches stay in step with the controller.
package microwave_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        ON   = 2'd1,
        BEEP = 2'd2
    } state_t;

    localparam logic [6:0] COOK_INC  = 7'd30;
    localparam logic [6:0] BEEP_TIME = 7'd4;

endpackage

// File: rtl/microwave_sm.sv
// Microwave oven control state machine.
//
// This block sends command strobes to an external 7-bit cook timer and
// drives the magnetron and the beeper. All outputs are Mealy: each one
// is combinational from the registered state and the current inputs.
//
// Ports:
//   clk     in   rising-edge system clock
//   rst_n   in   asynchronous active-low reset; forces OFF, outputs 0
//   press   in   Add30 button; each cycle it is high counts as one press
//   open    in   door sensor, 1 = door open
//   tmr_zr  in   external timer is zero
//   set30   out  load timer with COOK_INC
//   set4    out  load timer with BEEP_TIME
//   inc30   out  add COOK_INC to timer
//   dec     out  decrement timer by 1
//   on      out  magnetron on
//   beep    out  beeper on
//
// At most one strobe is high in any cycle. Overflow of the timer on
// inc30 is left to the timer.
module microwave_sm
    import microwave_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic press,
    input  logic open,
    input  logic tmr_zr,
    output logic set30,
    output logic set4,
    output logic inc30,
    output logic dec,
    output logic on,
    output logic beep
);

    state_t state;
    state_t stateNext;

    // State register. Reset returns the oven to idle regardless of the
    // clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OFF;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and output decode. The decode is gated by rst_n. During
    // reset the state is OFF, but a press would still reach the strobes
    // through the Mealy path. The gate holds every output at 0 while
    // reset is asserted.
    always_comb begin
        stateNext = state;
        set30     = 1'b0;
        set4      = 1'b0;
        inc30     = 1'b0;
        dec       = 1'b0;
        on        = 1'b0;
        beep      = 1'b0;

        if (rst_n) begin
            unique case (state)
                OFF: begin
                    // The timer is never decremented while idle.
                    // Closing the door on a nonzero timer resumes cooking.
                    if (press) begin
                        if (tmr_zr) set30 = 1'b1;
                        else        inc30 = 1'b1;
                        stateNext = open ? OFF : ON;
                    end else if (!open && !tmr_zr) begin
                        stateNext = ON;
                    end
                end

                ON: begin
                    // Opening the door stops cooking at once, with no
                    // decrement in that cycle. A press in the same cycle
                    // still adds time.
                    if (open) begin
                        stateNext = OFF;
                        if (press) begin
                            if (tmr_zr) set30 = 1'b1;
                            else        inc30 = 1'b1;
                        end
                    end else if (press) begin
                        if (tmr_zr) set30 = 1'b1;
                        else        inc30 = 1'b1;
                    end else if (tmr_zr) begin
                        set4      = 1'b1;
                        stateNext = BEEP;
                    end else begin
                        dec = 1'b1;
                    end
                    on = !open && !tmr_zr;
                end

                BEEP: begin
                    // The door is ignored here except on a press. A press
                    // then decides whether cooking restarts.
                    if (press) begin
                        set30     = 1'b1;
                        stateNext = open ? OFF : ON;
                    end else if (tmr_zr) begin
                        stateNext = OFF;
                    end else begin
                        dec = 1'b1;
                    end
                    beep = !tmr_zr;
                end

                default: begin
                    stateNext = OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_microwave_sm.sv
// Directed self-checking bench for microwave_sm.
//
// The bench models the external 7-bit cook timer. The model applies the
// DUT's strobes with priority set4 > set30 > inc30 > dec and feeds
// tmr_zr back to the DUT. Every expected output vector and timer value
// below is written out by hand.
//
// Output vector order: {set30, set4, inc30, dec, on, beep}.
module tb_microwave_sm;
    import microwave_pkg::*;

    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] S30  = 6'b100000;
    localparam logic [5:0] S4   = 6'b010000;
    localparam logic [5:0] I30  = 6'b001000;
    localparam logic [5:0] COOK = 6'b000110;
    localparam logic [5:0] BPD  = 6'b000101;

    logic clk;
    logic rst_n;
    logic press;
    logic open;
    logic tmr_zr;
    logic set30, set4, inc30, dec, on, beep;
    logic [6:0] timer;
    logic [5:0] outs;

    int testCount;
    int failCount;

    microwave_sm dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .press  (press),
        .open   (open),
        .tmr_zr (tmr_zr),
        .set30  (set30),
        .set4   (set4),
        .inc30  (inc30),
        .dec    (dec),
        .on     (on),
        .beep   (beep)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model of the external cook timer that the DUT commands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      timer <= 7'd0;
        else if (set4)   timer <= BEEP_TIME;
        else if (set30)  timer <= COOK_INC;
        else if (inc30)  timer <= timer + COOK_INC;
        else if (dec)    timer <= timer - 7'd1;
    end

    assign tmr_zr = (timer == 7'd0);
    assign outs   = {set30, set4, inc30, dec, on, beep};

    // Single comparison point. It counts every comparison and reports
    // any mismatch.
    task automatic checkOutput(input string tag, input logic [7:0] actual,
                               input logic [7:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, actual, expected);
        end
    endtask

    // Drives a new input pair shortly after a rising edge. It then waits
    // for the combinational outputs to settle before the caller samples.
    task automatic applyStimulus(input logic p, input logic o);
        @(posedge clk);
        #2;
        press = p;
        open  = o;
        #1;
    endtask

    // Applies one cycle of stimulus and checks both the output vector
    // and the timer value at the start of that cycle.
    task automatic stepCheck(input string tag, input logic p, input logic o,
                             input logic [5:0] expOut, input logic [6:0] expTimer);
        applyStimulus(p, o);
        checkOutput({tag, "_out"}, {2'b00, outs}, {2'b00, expOut});
        checkOutput({tag, "_tmr"}, {1'b0, timer}, {1'b0, expTimer});
        checkOutput({tag, "_1hot"}, 8'($countones({set30, set4, inc30, dec}) <= 1), 8'd1);
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        rst_n = 1'b0;
        press = 1'b1;
        open  = 1'b0;

        // Hold reset with press high. The outputs must stay at 0.
        #12;
        checkOutput("reset_out", {2'b00, outs}, 8'd0);
        checkOutput("reset_tmr", {1'b0, timer}, 8'd0);
        press = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Idle OFF with a zero timer.
        stepCheck("idle0", 1'b0, 1'b0, NONE, 7'd0);
        stepCheck("idle1", 1'b0, 1'b0, NONE, 7'd0);

        // Press from OFF with a zero timer loads 30 and starts cooking.
        stepCheck("start", 1'b1, 1'b0, S30, 7'd0);
        stepCheck("cook30", 1'b0, 1'b0, COOK, 7'd30);
        stepCheck("cook29", 1'b0, 1'b0, COOK, 7'd29);

        // Opening the door drops the magnetron with no decrement.
        stepCheck("doorOpen", 1'b0, 1'b1, NONE, 7'd28);
        stepCheck("offPressOpen", 1'b1, 1'b1, I30, 7'd28);
        stepCheck("offOpenIdle", 1'b0, 1'b1, NONE, 7'd58);

        // Closing the door on a nonzero timer resumes cooking.
        stepCheck("doorClose", 1'b0, 1'b0, NONE, 7'd58);
        for (int i = 0; i < 58; i++) begin
            stepCheck("cookDown", 1'b0, 1'b0, COOK, 7'(58 - i));
        end
        stepCheck("toBeep", 1'b0, 1'b0, S4, 7'd0);
        stepCheck("beep4", 1'b0, 1'b0, BPD, 7'd4);

        // A press during the beep reloads 30 and returns to cooking.
        // The beep output is still high in the cycle of the press.
        stepCheck("beepPress", 1'b1, 1'b0, S30 | 6'b000001, 7'd3);
        for (int i = 0; i < 30; i++) begin
            stepCheck("recook", 1'b0, 1'b0, COOK, 7'(30 - i));
        end
        stepCheck("toBeep2", 1'b0, 1'b0, S4, 7'd0);

        // Full beep. An open door must not change beeping.
        stepCheck("bp4", 1'b0, 1'b0, BPD, 7'd4);
        stepCheck("bp3", 1'b0, 1'b1, BPD, 7'd3);
        stepCheck("bp2", 1'b0, 1'b0, BPD, 7'd2);
        stepCheck("bp1", 1'b0, 1'b0, BPD, 7'd1);
        stepCheck("bpEnd", 1'b0, 1'b0, NONE, 7'd0);
        stepCheck("offAfter0", 1'b0, 1'b0, NONE, 7'd0);
        stepCheck("offAfter1", 1'b0, 1'b0, NONE, 7'd0);

        // Press in OFF with a zero timer and the door open: loads 30,
        // stays OFF.
        stepCheck("offSet30Open", 1'b1, 1'b1, S30, 7'd0);
        stepCheck("offHold", 1'b0, 1'b1, NONE, 7'd30);
        stepCheck("resume", 1'b0, 1'b0, NONE, 7'd30);

        // Press with the door opening during cooking: adds 30 and goes
        // to OFF.
        stepCheck("onOpenPress", 1'b1, 1'b1, I30, 7'd30);
        stepCheck("backOff", 1'b0, 1'b0, NONE, 7'd60);
        stepCheck("cook60", 1'b0, 1'b0, COOK, 7'd60);

        // Asynchronous reset while cooking clears the outputs at once.
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midReset_out", {2'b00, outs}, 8'd0);
        checkOutput("midReset_tmr", {1'b0, timer}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
